booth_multiplier_radix4_param: RTL
==================================

Name: booth_multiplier_radix4_param

Overview:
- Parametrised, iterative radix-4 Booth multiplier. Successor to the fixed 32-bit synchronous-reset multiplier.
- Adds generic operand width, a per-operation signed/unsigned mode, a busy indicator and back-to-back acceptance.
- Retires one radix-4 partial product per clock. Sits behind datapath control logic that issues one operation at a time with a valid pulse and consumes the result on a ready pulse.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and at least 4.
- CNT_W, 6, iteration counter width. Must satisfy 2**CNT_W > WIDTH/2+1.

Ports:
- clk  input  1  rising-edge clock.
- async_rst_n  input  1  asynchronous, active-low reset. Applies immediately; release is synchronised externally.
- valid  input  1  operation request. Sampled on a rising clk edge.
- signed_mode  input  1  1 = A, B and R are two's complement; 0 = unsigned. Sampled with valid.
- A  input  WIDTH  multiplicand.
- B  input  WIDTH  multiplier.
- R  output  2*WIDTH  product. Registered.
- ready  output  1  one-cycle pulse: R is valid.
- busy  output  1  high while an operation is in CALC.

Behaviour:
- Reset (async_rst_n=0, any time, including mid-operation): state=IDLE, R=0, ready=0, busy=0, counter=0, internal registers cleared. No partial result survives.
- States: IDLE, CALC, DONE.
- Accept rule: valid=1 at an edge while state is IDLE or DONE (busy=0) accepts the operation at that edge (t0). valid while busy=1 is ignored, not queued.
- At t0:
  - A and B are extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - The multiplier is loaded with an appended 0 LSB, the accumulator is cleared, counter=0, state goes to CALC, busy=1.
- Each CALC edge performs one step:
  - Examine multiplier triplet {b[2i+1], b[2i], b[2i-1]} and select 0, +M, +2M, -M or -2M (M = extended A).
  - Add the selection into the upper accumulator, then arithmetic-shift the accumulator/multiplier pair right 2 bits.
- Number of steps N = WIDTH/2+1 (17 for WIDTH=32).
- At edge t0+N: R takes the low 2*WIDTH bits of the result, ready=1, busy=0, state goes to DONE.
- At edge t0+N+1: ready=0. State goes to IDLE, or to CALC if valid=1 at that edge (back-to-back accept).
- R holds its value until the next operation completes. It is never updated mid-calculation.
- Latency: ready is high in the cycle following edge t0+N. For WIDTH=32 that is 17 edges after accept.
- Arithmetic:
  - Internal accumulator is 2*(WIDTH+2)+1 bits, so -2M never overflows.
  - The result is exact for all inputs, including most-negative × most-negative in signed mode and all-ones × all-ones in unsigned mode.
- signed_mode, A and B are ignored except at the accept edge.

Optional Feature:
- Macro: BOOTH_EARLY_DONE_EN.
- Defined: if A==0 or B==0 at the accept edge, skip CALC. At edge t0+1, R=0, ready=1, state=DONE, and busy is never asserted.
- Undefined: zero operands take the full N-step latency like any other operand.

Test Plan:
- Reset mid-op: WIDTH=32, accept A=123456, B=654321, pull async_rst_n low for 3 ns at step 8 -> R=0, ready=0, busy=0 immediately. After release, a new accept of 3×5 gives R=15.
- Signed corners: WIDTH=32, signed_mode=1, A=0x80000000, B=0x80000000 -> R=0x4000000000000000, ready exactly 17 edges after accept. Also A=-7, B=6 -> R=-42 (0xFFFFFFFFFFFFFFD6).
- Unsigned corner: WIDTH=32, signed_mode=0, A=B=0xFFFFFFFF -> R=0xFFFFFFFE00000001. The same operands with signed_mode=1 give R=1.
- Handshake: valid held high continuously -> second operation accepted only at the edge where ready is seen, i.e. one result every 18 edges. valid pulses during busy leave R and timing unchanged.
- WIDTH=8 instance: exhaustive 256×256 sweep in both modes against a reference product. ready exactly 5 edges after each accept.
- BOOTH_EARLY_DONE_EN: A=0, B=0xDEADBEEF -> R=0 with ready 1 edge after accept. Without the macro -> R=0 with ready 17 edges after accept.

Source files
------------

// File: rtl/booth_multiplier_radix4_param.sv
// Iterative radix-4 Booth multiplier: WIDTH-bit operands, signed/unsigned per operation, one partial product per clock.
// Optional BOOTH_EARLY_DONE_EN: a zero operand completes one edge after accept, without entering CALC.
module booth_multiplier_radix4_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               async_rst_n,
    input  logic               valid,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] R,
    output logic               ready,
    output logic               busy
);
    localparam int EXT   = WIDTH + 2;
    localparam int ACC_W = 2 * EXT + 1;
    localparam int STEPS = WIDTH / 2 + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [EXT-1:0]   m_q;
    logic [ACC_W-1:0] acc_q, acc_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [EXT-1:0]   a_ext, b_ext;
    logic [EXT:0]     m_wide, u_wide, sel, sum;
    logic             accept, last_step, zero_op, zero_pend;

    assign a_ext = {{2{signed_mode & A[WIDTH-1]}}, A};
    assign b_ext = {{2{signed_mode & B[WIDTH-1]}}, B};

`ifdef BOOTH_EARLY_DONE_EN
    assign zero_op = (A == '0) || (B == '0);

    // Zero-operand requests wait one edge in IDLE, then jump straight to DONE.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) zero_pend <= 1'b0;
        else              zero_pend <= accept && zero_op;
    end
`else
    assign zero_op   = 1'b0;
    assign zero_pend = 1'b0;
`endif

    assign busy      = (state == CALC);
    assign ready     = (state == DONE);
    assign accept    = valid && !busy && !zero_pend;
    assign last_step = (cnt_q == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) state <= IDLE;
        else              state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (zero_pend)              state_nxt = DONE;
                else if (accept && !zero_op) state_nxt = CALC;
            end
            CALC:    if (last_step) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // One Booth step: the low three bits of acc_q are the current multiplier triplet.
    assign m_wide = {m_q[EXT-1], m_q};
    assign u_wide = {acc_q[ACC_W-1], acc_q[ACC_W-1 -: EXT]};

    always_comb begin
        sel = '0;
        case (acc_q[2:0])
            3'b001, 3'b010: sel = m_wide;
            3'b011:         sel = m_wide << 1;
            3'b100:         sel = -(m_wide << 1);
            3'b101, 3'b110: sel = -m_wide;
            default:        sel = '0;
        endcase
    end

    assign sum     = u_wide + sel;
    // Arithmetic right shift by two of {sum, multiplier}; the dropped top bit is a sign copy.
    assign acc_nxt = {sum[EXT], sum, acc_q[EXT:2]};

    // NOTE: datapath registers are reset too, so an aborted operation leaves no partial result behind.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            m_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            R     <= '0;
        end else begin
            if (accept) begin
                m_q   <= a_ext;
                acc_q <= {{EXT{1'b0}}, b_ext, 1'b0};
                cnt_q <= '0;
            end else if (state == CALC) begin
                acc_q <= acc_nxt;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_step) R <= acc_nxt[2*WIDTH:1];
            end
            if (zero_pend) R <= '0;
        end
    end
endmodule
